// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its consumers.
// Holds the FSM encoding, PC increment and instruction width used by decode as well.
package fetch_stage_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_INCR = 32'd4;
  localparam int          INSTR_W = 32;

endpackage

// File: rtl/fetch_stage_if.sv
// Request/acknowledge bus between the fetch stage and instruction memory.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [31:0]        IMem_Addr;
  logic               IMem_Req;
  logic [INSTR_W-1:0] IMem_Data;
  logic               IMem_Ack;

  modport master (
    output IMem_Addr,
    output IMem_Req,
    input  IMem_Data,
    input  IMem_Ack
  );

  modport slave (
    input  IMem_Addr,
    input  IMem_Req,
    output IMem_Data,
    output IMem_Ack
  );

endinterface

// File: rtl/fetch_stage_pc_next.sv
// Next-PC adder: sequential PC+4 or branch-relative PC+4+(offset<<2), modulo 2^32.
module fetch_stage_pc_next
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] immed_i,
  input  logic        sel_i,
  output logic [31:0] pc_next_o
);

  logic [31:0] seq_pc;
  logic [31:0] offset;

  // Shifting in 32 bits drops immed_i[31:30], matching the word-offset encoding.
  always_comb begin
    seq_pc    = pc_i + PC_INCR;
    offset    = sel_i ? (immed_i << 2) : 32'd0;
    pc_next_o = seq_pc + offset;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack bus and
// holds the returned word in an instruction register until the next PC load.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PC_sel,
  input  logic               PC_LdEn,
  input  logic [31:0]        PC_Immed,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] Instr,
  output logic               Instr_Valid,
  output logic [31:0]        PC,
  output logic               Busy,
  output logic               Fetch_Err
);

  localparam int             CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [31:0]        pc_next_w;

  fetch_stage_pc_next u_pc_next (
    .pc_i      (pc_q),
    .immed_i   (PC_Immed),
    .sel_i     (PC_sel),
    .pc_next_o (pc_next_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // A missing ack never abandons the fetch; it only saturates the counter and flags the error.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_REQ: begin
        if (imem.IMem_Ack) begin
          instr_d = imem.IMem_Data;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) err_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (PC_LdEn) begin
          pc_d    = pc_next_w;
          valid_d = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Req is gated by rst so an outstanding request drops the instant reset rises.
  always_comb begin
    imem.IMem_Req  = (state_q == S_REQ) && !rst;
    imem.IMem_Addr = pc_q;
    Busy           = (state_q == S_REQ);
    Instr          = instr_q;
    Instr_Valid    = valid_q;
    PC             = pc_q;
    Fetch_Err      = err_q;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the decode stage.
- Owns the program counter and issues a request/acknowledge fetch to instruction memory.
- Latches the returned word into an instruction register that drives decode's Instr input, and holds it stable until control commands the next PC load.
- Next PC is sequential (PC+4) or branch-relative (PC+4+(PC_Immed<<2)).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 00.
- TIMEOUT, 16, IMem_Ack wait cycles tolerated before Fetch_Err sets; must be >= 1.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PC_sel  in  1  0: next PC = PC+4; 1: next PC = PC+4+(PC_Immed<<2).
- PC_LdEn  in  1  control pulse: advance PC and start next fetch.
- PC_Immed  in  32  sign-extended word offset from decode Immed.
- IMem_Addr  out  32  fetch address, equals PC.
- IMem_Req  out  1  fetch request to instruction memory.
- IMem_Data  in  32  instruction word, valid when IMem_Ack=1.
- IMem_Ack  in  1  memory acknowledge, single-cycle.
- Instr  out  32  registered instruction to decode.
- Instr_Valid  out  1  Instr holds the word fetched from the current PC.
- PC  out  32  current program counter.
- Busy  out  1  fetch in progress; PC_LdEn ignored.
- Fetch_Err  out  1  sticky: an ack wait exceeded TIMEOUT.

Behaviour:
- Reset (async, active-high) forces:
  - PC = RESET_PC; Instr = 0; Instr_Valid = 0; Fetch_Err = 0.
  - Wait counter = 0; state = S_REQ.
  - IMem_Req = 0 while Reset is high.
- States:
  - S_REQ: IMem_Req=1, Busy=1, IMem_Addr=PC.
  - S_HOLD: IMem_Req=0, Busy=0, Instr stable.
- S_REQ, IMem_Ack=1 sampled at the edge:
  - Instr <= IMem_Data; Instr_Valid <= 1; wait counter <= 0; go S_HOLD.
  - Ack may arrive in the same cycle Req first rises, giving 1-cycle fetch latency.
- S_REQ, IMem_Ack=0:
  - Wait counter increments, saturating at TIMEOUT.
  - When the counter reaches TIMEOUT, Fetch_Err <= 1 (sticky until Reset).
  - Request stays asserted; the fetch is not abandoned.
- S_HOLD, PC_LdEn=1:
  - PC <= next PC per PC_sel; Instr_Valid <= 0; go S_REQ.
  - Instr keeps its old value until the new ack (no bubble write).
- S_HOLD, PC_LdEn=0: all state held indefinitely.
- Ignored inputs:
  - PC_LdEn in S_REQ is ignored; control must wait for Busy=0.
  - IMem_Ack in S_HOLD is ignored and IMem_Data is not captured.
- Arithmetic:
  - 32-bit modulo 2^32; PC_Immed<<2 discards the top two bits.
  - PC+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - Branch target = (PC+4) + {PC_Immed[29:0],2'b00}, so negative offsets work.
- PC_sel is sampled only on the PC_LdEn edge.
- Reset asserted mid-fetch:
  - Outstanding request is dropped immediately.
  - The memory side must tolerate Req falling without an ack.
- First fetch after reset release:
  - IMem_Req rises combinationally from S_REQ once Reset is low.
  - First ack captures the word at RESET_PC.

Decomposition:
- Shared package holds:
  - state encoding (S_REQ, S_HOLD);
  - PC_INCR = 32'd4;
  - instruction width constant (32) used also by decode.
- One sub-module, pc_next: combinational, computes next PC from PC, PC_Immed and PC_sel.
- FSM, PC register, instruction register and wait counter live in fetch_stage.

Test Plan:
- Reset then ack on first cycle with IMem_Data=32'h2001_0005 -> IMem_Addr=0, Instr=32'h2001_0005, Instr_Valid=1, Busy=0 one edge after ack.
- PC_LdEn=1, PC_sel=0 at PC=0x10 -> PC=0x14, Instr_Valid=0, IMem_Req=1, IMem_Addr=0x14; old Instr held until ack.
- PC_sel=1, PC_Immed=32'hFFFF_FFFE at PC=0x20 -> PC=0x1C; PC_Immed=3 at PC=0x20 -> PC=0x30.
- PC=32'hFFFF_FFFC, PC_LdEn=1, PC_sel=0 -> PC=0.
- Ack withheld 20 cycles with TIMEOUT=16 -> Fetch_Err=1 after the 16th wait cycle, Req still 1; late ack captured; Fetch_Err stays 1 until Reset.
- Checks on ignored and dropped events:
  - PC_LdEn pulsed while Busy=1 -> PC unchanged.
  - Ack pulsed in S_HOLD -> Instr unchanged.
  - Reset asserted mid-wait -> PC=RESET_PC, Req=0 asynchronously.
